// File: rtl/io_input_if.sv
// Handshake and board-pin bundle between the CPU I/O unit / board and the IN responder.
// The slave side is the responder; the master side is whatever drives request, switches and button.
interface io_input_if #(parameter int DATA_W = 32);
  logic              req_in;
  logic              btn;
  logic [3:0]        sw;
  logic [DATA_W-1:0] data_out;
  logic              ack;
  logic              busy;
  logic              err;
  logic [3:0]        dig_uni;
  logic [3:0]        dig_dez;
  logic [3:0]        dig_cen;

  modport slave (
    input  req_in, btn, sw,
    output data_out, ack, busy, err, dig_uni, dig_dez, dig_cen
  );

  modport master (
    output req_in, btn, sw,
    input  data_out, ack, busy, err, dig_uni, dig_dez, dig_cen
  );
endinterface

// File: rtl/io_input_responder.sv
// Answers the CPU IN instruction: collects up to three BCD digits from switches on button
// presses, converts them to binary and returns the value over a four-phase req/ack handshake.
//
// state   | meaning
// IDLE    | no request; digits hold last entry for display
// COLLECT | accepting digit / ENTER presses
// CONVERT | one cycle to build the binary value
// DONE    | ack held until the CPU drops its request
module io_input_responder #(
  parameter int DATA_W     = 32,
  parameter int AUTO_ENTER = 1
) (
  input  logic        clk,
  input  logic        reset,
  io_input_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, CONVERT, DONE} state_t;

  state_t            state, state_nx;
  logic              btn_q;
  logic [1:0]        cnt, cnt_nx;
  logic [3:0]        uni, dez, cen, uni_nx, dez_nx, cen_nx;
  logic [DATA_W-1:0] data, data_nx;
  logic              ack, busy, err, err_nx;
  logic              press, is_digit, is_enter, accept;
  logic [9:0]        c10, d10, u10, value;

  assign press    = bus.btn & ~btn_q;
  assign is_digit = (bus.sw <= 4'd9);
  assign is_enter = (bus.sw == 4'hF);
  // With AUTO_ENTER=0 a fourth digit is silently dropped; only ENTER completes.
  assign accept   = (state == COLLECT) && bus.req_in && press && is_digit && (cnt != 2'd3);

  assign c10   = {6'd0, cen};
  assign d10   = {6'd0, dez};
  assign u10   = {6'd0, uni};
  assign value = (c10 << 6) + (c10 << 5) + (c10 << 2) + (d10 << 3) + (d10 << 1) + u10;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      btn_q <= 1'b0;
      cnt   <= 2'd0;
      uni   <= 4'd0;
      dez   <= 4'd0;
      cen   <= 4'd0;
      data  <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      btn_q <= bus.btn;
      cnt   <= cnt_nx;
      uni   <= uni_nx;
      dez   <= dez_nx;
      cen   <= cen_nx;
      data  <= data_nx;
      ack   <= (state_nx == DONE);
      busy  <= (state_nx == COLLECT) || (state_nx == CONVERT);
      err   <= err_nx;
    end
  end

  // Abort (request dropped) is checked before any press so it always wins.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_in) state_nx = COLLECT;
      COLLECT: begin
        if (!bus.req_in)                                      state_nx = IDLE;
        else if (press && is_enter)                           state_nx = CONVERT;
        else if (accept && cnt == 2'd2 && AUTO_ENTER != 0)    state_nx = CONVERT;
      end
      CONVERT: state_nx = bus.req_in ? DONE : IDLE;
      DONE:    if (!bus.req_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx  = cnt;
    uni_nx  = uni;
    dez_nx  = dez;
    cen_nx  = cen;
    data_nx = data;
    err_nx  = (state == COLLECT) && bus.req_in && press && !is_digit && !is_enter;
    if (state == IDLE && bus.req_in) begin
      cnt_nx = 2'd0;
      uni_nx = 4'd0;
      dez_nx = 4'd0;
      cen_nx = 4'd0;
    end else if (accept) begin
      cnt_nx = cnt + 2'd1;
      uni_nx = bus.sw;
      dez_nx = uni;
      cen_nx = dez;
    end else if (state == CONVERT && bus.req_in) begin
      data_nx = DATA_W'(value);
    end
  end

  assign bus.data_out = data;
  assign bus.ack      = ack;
  assign bus.busy     = busy;
  assign bus.err      = err;
  assign bus.dig_uni  = uni;
  assign bus.dig_dez  = dez;
  assign bus.dig_cen  = cen;

endmodule

// File: tb/tb_io_input_responder.sv
// Bench for io_input_responder: table of entries against an auto-enter instance, plus
// hand-written sequences for err, held button, abort, reset and the manual-enter instance.
module tb_io_input_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_input_if #(.DATA_W(32)) ifa ();
  io_input_if #(.DATA_W(32)) ifm ();

  io_input_responder #(.DATA_W(32), .AUTO_ENTER(1)) u_auto (.clk(clk), .reset(reset), .bus(ifa.slave));
  io_input_responder #(.DATA_W(32), .AUTO_ENTER(0)) u_man  (.clk(clk), .reset(reset), .bus(ifm.slave));

  typedef struct {
    int         n;
    logic [3:0] k [4];
    logic [3:0] cen, dez, uni;
    int         val;
  } vec_t;

  vec_t vecs [7];
  int   exp_q [$];
  int   total = 0;
  int   passed = 0;
  int   err_a = 0;
  int   err_m = 0;

  always @(negedge clk) begin
    err_a += int'(ifa.err);
    err_m += int'(ifm.err);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic setv(input int i, input int n, input logic [3:0] k0, k1, k2, k3,
                      input logic [3:0] c, d, u, input int val);
    vecs[i].n = n;
    vecs[i].k[0] = k0; vecs[i].k[1] = k1; vecs[i].k[2] = k2; vecs[i].k[3] = k3;
    vecs[i].cen = c; vecs[i].dez = d; vecs[i].uni = u; vecs[i].val = val;
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    ifa.sw = v; ifm.sw = v; ifa.btn = 1'b1; ifm.btn = 1'b1;
    @(negedge clk);
    ifa.btn = 1'b0; ifm.btn = 1'b0;
  endtask

  task automatic wait_ack(input bit man);
    int i;
    for (i = 0; i < 20; i++) begin
      if ((man ? ifm.ack : ifa.ack) === 1'b1) break;
      @(negedge clk);
    end
    if (i == 20) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop_req_a();
    @(negedge clk); ifa.req_in = 1'b0;
    @(negedge clk);
    chk("ack_fall", 32'(ifa.ack), 32'd0);
  endtask

  initial begin
    int e0, v;
    ifa.req_in = 1'b0; ifa.btn = 1'b0; ifa.sw = 4'd0;
    ifm.req_in = 1'b0; ifm.btn = 1'b0; ifm.sw = 4'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ifa.ack), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_data", ifa.data_out, 32'd0);
    reset = 1'b0;

    setv(0, 3, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 123);
    setv(1, 3, 4'd9, 4'd7, 4'hF, 4'd0, 4'd0, 4'd9, 4'd7, 97);
    setv(2, 1, 4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0);
    setv(3, 3, 4'd9, 4'd9, 4'd9, 4'd0, 4'd9, 4'd9, 4'd9, 999);
    setv(4, 3, 4'd4, 4'd0, 4'd7, 4'd0, 4'd4, 4'd0, 4'd7, 407);
    setv(5, 2, 4'd6, 4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 6);
    setv(6, 3, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 5);

    // Exact 2-edge latency from the final press to ack.
    @(negedge clk); ifa.req_in = 1'b1;
    @(negedge clk);
    chk("busy_collect", 32'(ifa.busy), 32'd1);
    press(4'd1); press(4'd2); press(4'd3);
    chk("ack_after_E", 32'(ifa.ack), 32'd0);
    @(negedge clk);
    chk("ack_after_E1", 32'(ifa.ack), 32'd1);
    chk("data_123", ifa.data_out, 32'd123);
    drop_req_a();

    foreach (vecs[i]) begin
      @(negedge clk); ifa.req_in = 1'b1;
      @(negedge clk);
      for (int j = 0; j < vecs[i].n; j++) press(vecs[i].k[j]);
      exp_q.push_back(vecs[i].val);
      wait_ack(1'b0);
      v = exp_q.pop_front();
      chk($sformatf("vec%0d_data", i), ifa.data_out, 32'(v));
      chk($sformatf("vec%0d_cen", i), 32'(ifa.dig_cen), 32'(vecs[i].cen));
      chk($sformatf("vec%0d_dez", i), 32'(ifa.dig_dez), 32'(vecs[i].dez));
      chk($sformatf("vec%0d_uni", i), 32'(ifa.dig_uni), 32'(vecs[i].uni));
      drop_req_a();
    end

    // Invalid code pulses err for one cycle; held button accepted once.
    @(negedge clk); ifa.req_in = 1'b1;
    @(negedge clk);
    press(4'd4);
    e0 = err_a;
    @(negedge clk); ifa.sw = 4'hB; ifa.btn = 1'b1;
    @(negedge clk); ifa.btn = 1'b0;
    chk("err_high", 32'(ifa.err), 32'd1);
    @(negedge clk);
    chk("err_low", 32'(ifa.err), 32'd0);
    chk("err_count", 32'(err_a - e0), 32'd1);
    chk("bad_uni", 32'(ifa.dig_uni), 32'd4);
    chk("bad_dez", 32'(ifa.dig_dez), 32'd0);
    ifa.sw = 4'd5; ifa.btn = 1'b1;
    repeat (20) @(negedge clk);
    ifa.btn = 1'b0;
    @(negedge clk);
    chk("held_uni", 32'(ifa.dig_uni), 32'd5);
    chk("held_dez", 32'(ifa.dig_dez), 32'd4);
    chk("held_cen", 32'(ifa.dig_cen), 32'd0);
    chk("held_busy", 32'(ifa.busy), 32'd1);
    press(4'hF);
    exp_q.push_back(45);
    wait_ack(1'b0);
    v = exp_q.pop_front();
    chk("held_data", ifa.data_out, 32'(v));
    drop_req_a();

    // Abort wins over a press on the same edge.
    @(negedge clk); ifa.req_in = 1'b1;
    @(negedge clk);
    press(4'd8);
    @(negedge clk); ifa.sw = 4'd3; ifa.btn = 1'b1; ifa.req_in = 1'b0;
    @(negedge clk); ifa.btn = 1'b0;
    chk("abort_busy", 32'(ifa.busy), 32'd0);
    chk("abort_uni", 32'(ifa.dig_uni), 32'd8);
    chk("abort_dez", 32'(ifa.dig_dez), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_ack", 32'(ifa.ack), 32'd0);
    chk("abort_data", ifa.data_out, 32'd45);

    // Asynchronous reset mid-entry.
    @(negedge clk); ifa.req_in = 1'b1;
    @(negedge clk);
    press(4'd4); press(4'd2);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(ifa.busy), 32'd0);
    chk("rstmid_ack", 32'(ifa.ack), 32'd0);
    chk("rstmid_data", ifa.data_out, 32'd0);
    chk("rstmid_digs", {20'd0, ifa.dig_cen, ifa.dig_dez, ifa.dig_uni}, 32'd0);
    ifa.req_in = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_idle", 32'(ifa.busy), 32'd0);

    // Manual-enter instance: fourth digit ignored, ENTER completes.
    @(negedge clk); ifm.req_in = 1'b1;
    @(negedge clk);
    e0 = err_m;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    repeat (2) @(negedge clk);
    chk("man_cen", 32'(ifm.dig_cen), 32'd1);
    chk("man_dez", 32'(ifm.dig_dez), 32'd2);
    chk("man_uni", 32'(ifm.dig_uni), 32'd3);
    chk("man_noack", 32'(ifm.ack), 32'd0);
    chk("man_noerr", 32'(err_m - e0), 32'd0);
    press(4'hF);
    exp_q.push_back(123);
    wait_ack(1'b1);
    v = exp_q.pop_front();
    chk("man_data", ifm.data_out, 32'(v));
    @(negedge clk); ifm.req_in = 1'b0;
    @(negedge clk);
    chk("man_ack_fall", 32'(ifm.ack), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_input_responder.md
# io_input_responder

Device-side responder for the CPU's `IN` instruction. While the CPU holds an input request, the block collects up to three decimal digits from the 4-bit board switches, one per debounced button press. It converts them to a binary value, returns that value with a four-phase request/acknowledge handshake, and drives the entered digits to the 7-segment decoders. It sits between the I/O unit and the board switch/button/display pins, and replaces ad-hoc halt-until-button input.

## Interface
- `DATA_W`, default 32: width of `data_out`; must be >= 10.
- `AUTO_ENTER`, default 1: 1 = complete automatically after the third digit; 0 = completion only via the ENTER code.

- `clk`  in  1: system clock (divided CPU clock).
- `reset`  in  1: asynchronous, active-high.
- `req_in`  in  1: CPU input request, level; held until `ack` is seen.
- `btn`  in  1: debounced button level, active-high.
- `sw`  in  4: switch value. 0–9 = digit, 4'hF = ENTER, 4'hA–4'hE = invalid.
- `data_out`  out  DATA_W: converted value; stable while `ack`=1 and retained until the next request.
- `ack`  out  1: acknowledge, level.
- `busy`  out  1: high in COLLECT and CONVERT.
- `err`  out  1: one-cycle pulse on an invalid-code press.
- `dig_uni`, `dig_dez`, `dig_cen`  out  4 each: BCD digits for the display decoders.

## Operation
- Button edge: `btn_q` is a registered copy of `btn`. `press = btn & ~btn_q`. Only edges count; a held button counts once.
- `cnt` (2 bits) holds the number of accepted digits, 0–3.
- States:
  - IDLE: `busy`=0, `ack`=0. When `req_in`=1: clear all three digits and `cnt`, go to COLLECT.
  - COLLECT: on `press`:
    - `sw` <= 9: shift the digits (`cen<=dez`, `dez<=uni`, `uni<=sw`) and increment `cnt`. If `cnt` becomes 3 and `AUTO_ENTER`=1, go to CONVERT.
    - `sw` = F: go to CONVERT. Valid with `cnt`=0, which yields value 0.
    - `sw` = A–E: pulse `err`; digits and `cnt` unchanged.
    - When `AUTO_ENTER`=0 and `cnt`=3, further digit presses are ignored with no `err`; only ENTER completes.
  - CONVERT: load `data_out = cen*100 + dez*10 + uni`, using shift-add (`c<<6 + c<<5 + c<<2`, `d<<3 + d<<1`), zero-extended to `DATA_W`. Set `ack`<=1 and go to DONE.
  - DONE: hold `ack`=1. When `req_in`=0, clear `ack` and go to IDLE.
- Abort: if `req_in` drops in COLLECT or CONVERT, go to IDLE with no `ack` and `data_out` unchanged. Abort takes priority over a simultaneous `press`.
- In DONE and IDLE, presses are ignored and the digits keep the last entry for display.
- Value range is 0–999; no overflow is possible.

## Timing
- Reset (asynchronous, immediate) values:
  - state = IDLE
  - `ack`=0, `busy`=0, `err`=0
  - `data_out`=0
  - all digits = 0, `cnt`=0, `btn_q`=0
- The request is sampled at the first clock edge with `req_in`=1. COLLECT and `busy`=1 are visible after that edge.
- A press is recognized at edge E, where `btn`=1 and `btn_q`=0 are sampled. The digit updates at E.
- If E completes the entry: CONVERT after E; `data_out` valid and `ack`=1 after E+1. Latency from the final press to ack is 2 edges.
- `ack` falls at the first edge where `req_in`=0 is sampled in DONE. A new request is accepted no earlier than the following edge, since IDLE must be entered first.
- `err` is high for exactly the one cycle following edge E.
- Reset asserted mid-entry discards the entry. After release the block waits in IDLE and does not resume.
- All outputs are registered.

## Test plan
- Reset then idle: assert `reset` mid-COLLECT with digits 4,2 entered -> immediately `ack`=0, `busy`=0, `data_out`=0, digits=0.
- Three-digit entry, `AUTO_ENTER`=1: `req_in`=1; press `sw`=1, 2, 3 -> `dig_cen`/`dez`/`uni`=1/2/3, `ack`=1 two edges after the third press, `data_out`=123. Drop `req_in` -> `ack`=0 one edge later.
- Short entry with ENTER: press 9, 7, then F -> `data_out`=97. Press F alone on a new request -> `data_out`=0, `ack`=1.
- Invalid code and held button:
  - press `sw`=B -> one-cycle `err`, `cnt` unchanged.
  - hold `btn` high for 20 cycles with `sw`=5 -> exactly one digit 5 accepted.
  - press 9, 9, 9 -> `data_out`=999.
- Abort: press 8, drop `req_in` on the same edge as a second press -> IDLE, no `ack`, `data_out` keeps its prior value, and the second digit is not accepted.
- `AUTO_ENTER`=0: press 1, 2, 3, 4 -> `cnt` stays 3, no `ack`, no `err`. Then F -> `data_out`=123.
